lsls_seq: RTL and testbench

- Sequential logical-left-shift unit for the ALU; the left-direction counterpart of the ALU's combinational logical right shifter.
- Uses a log-stage iterative barrel: one conditional power-of-two stage per clock, largest stage first.
- Has a start/busy/done handshake so the ALU controller can issue back-to-back shifts.
- Produces the shifted word and a carry-out equal to the last bit shifted out of the MSB end.

---
 rtl/lsls_seq.sv | 110 +++++++++++
 tb/tb_lsls_seq.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/lsls_seq.sv
// lsls_seq: sequential logical left shifter with carry-out.
//
// One conditional power-of-two shift stage is applied per clock, largest
// stage first, so every operation takes exactly SHW RUN cycles regardless
// of the shift amount. A start/busy/done handshake lets the controller
// issue a new operation in the DONE cycle for back-to-back throughput.
//
// Ports:
//   clk     - clock, rising edge
//   rst     - synchronous active-high reset
//   start   - request a shift (sampled only when not busy)
//   num     - operand, captured on an accepted start
//   shifts  - shift amount 0..WIDTH-1, captured on an accepted start
//   busy    - high while the shift is running
//   done    - one-cycle pulse when shifted/c_out carry a new result
//   shifted - num << shifts, zero-filled
//   c_out   - last bit shifted out of the MSB end (0 when shifts == 0)

module lsls_seq #(
    parameter int unsigned WIDTH = 32,
    localparam int unsigned SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] num,
    input  logic [SHW-1:0]   shifts,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] shifted,
    output logic             c_out
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] data_q;
    logic [SHW-1:0]   amt_q;
    logic [SHW-1:0]   stage_q;
    logic             carry_q;

    logic [SHW:0]       step;
    logic [2*WIDTH-1:0] wide;
    logic [WIDTH-1:0]   data_nxt;
    logic               carry_nxt;

    // Shifting a double-width copy leaves the last bit pushed out of the
    // MSB end at position WIDTH, i.e. data_q[WIDTH-step].
    always_comb begin
        step      = {{SHW{1'b0}}, 1'b1} << stage_q;
        wide      = {{WIDTH{1'b0}}, data_q} << step;
        data_nxt  = data_q;
        carry_nxt = carry_q;
        if (amt_q[stage_q]) begin
            data_nxt  = wide[WIDTH-1:0];
            carry_nxt = wide[WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            data_q  <= '0;
            amt_q   <= '0;
            stage_q <= '0;
            carry_q <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            shifted <= '0;
            c_out   <= 1'b0;
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    done <= 1'b0;
                    if (start) begin
                        data_q  <= num;
                        amt_q   <= shifts;
                        stage_q <= SHW'(SHW - 1);
                        carry_q <= 1'b0;
                        busy    <= 1'b1;
                        state_q <= StRun;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StRun: begin
                    data_q  <= data_nxt;
                    carry_q <= carry_nxt;
                    if (stage_q == '0) begin
                        // Results are published only here, so they stay
                        // stable through IDLE and the following RUN.
                        shifted <= data_nxt;
                        c_out   <= carry_nxt;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        stage_q <= stage_q - 1'b1;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsls_seq.sv
module tb_lsls_seq;

    typedef struct packed {
        logic        c;
        logic [31:0] sh;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] num;
    logic [4:0]  shifts;
    logic        busy;
    logic        done;
    logic [31:0] shifted;
    logic        c_out;

    int checks   = 0;
    int failures = 0;

    exp_t sb[$];

    logic        hold_valid = 1'b0;
    logic [31:0] hold_sh;
    logic        hold_c;

    lsls_seq #(.WIDTH(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .num     (num),
        .shifts  (shifts),
        .busy    (busy),
        .done    (done),
        .shifted (shifted),
        .c_out   (c_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] n, input logic [4:0] s);
        exp_t e;
        int   idx;
        e.sh = n << s;
        idx  = 32 - int'(s);
        e.c  = (s == 5'd0) ? 1'b0 : n[idx];
        return e;
    endfunction

    // Called at posedge+1 with the DUT idle; returns at posedge+1 after
    // the accepting edge.
    task automatic issue(input logic [31:0] n, input logic [4:0] s, input exp_t e);
        num    = n;
        shifts = s;
        start  = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (done) break;
        end
        if (!done) check("done_timeout", 64'(n), 64'(0));
        @(posedge clk);
        #1;
    endtask

    // Scoreboard and output-stability monitor.
    always @(negedge clk) begin
        if (rst) begin
            hold_valid = 1'b0;
        end else if (done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 64'(1), 64'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("shifted", 64'(shifted), 64'(e.sh));
                check("c_out", 64'(c_out), 64'(e.c));
            end
            hold_sh    = shifted;
            hold_c     = c_out;
            hold_valid = 1'b1;
        end else if (hold_valid) begin
            check("hold", {31'd0, c_out, shifted}, {31'd0, hold_c, hold_sh});
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int cnt;
        logic [31:0] rn;
        logic [4:0]  rs;

        rst    = 1'b1;
        start  = 1'b0;
        num    = '0;
        shifts = '0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_shifted", 64'(shifted), 64'(0));
        check("rst_c_out", 64'(c_out), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Basic latency: 5 busy cycles, then a single done cycle.
        issue(32'h0000_0001, 5'd4, '{c: 1'b0, sh: 32'h0000_0010});
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t1_busy", 64'(busy), 64'(1));
            check("t1_done", 64'(done), 64'(0));
        end
        @(negedge clk);
        check("t1_busy_end", 64'(busy), 64'(0));
        check("t1_done_end", 64'(done), 64'(1));
        @(posedge clk);
        #1;
        @(negedge clk);
        check("t1_done_pulse", 64'(done), 64'(0));
        @(posedge clk);
        #1;

        issue(32'h8000_0001, 5'd1, '{c: 1'b1, sh: 32'h0000_0002});
        wait_done(n);
        issue(32'hF000_0000, 5'd4, '{c: 1'b1, sh: 32'h0000_0000});
        wait_done(n);

        // Zero shift still takes the full latency.
        issue(32'hDEAD_BEEF, 5'd0, '{c: 1'b0, sh: 32'hDEAD_BEEF});
        wait_done(n);
        check("zero_latency", 64'(n), 64'(6));
        issue(32'h0000_0003, 5'd31, '{c: 1'b1, sh: 32'h8000_0000});
        wait_done(n);
        check("max_latency", 64'(n), 64'(6));

        // Back-to-back with ignored start pulse during busy.
        issue(32'h0000_0001, 5'd3, '{c: 1'b0, sh: 32'h0000_0008});
        @(posedge clk); #1;
        start = 1'b1; num = 32'hFFFF_FFFF; shifts = 5'd5;
        @(posedge clk); #1;
        start = 1'b0; num = 32'h1234_5678;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        num = 32'h0000_00FF; shifts = 5'd8; start = 1'b1;
        sb.push_back('{c: 1'b0, sh: 32'h0000_FF00});
        @(negedge clk);
        check("b2b_first_done", 64'(done), 64'(1));
        @(posedge clk); #1;
        start = 1'b0; num = 32'hAAAA_AAAA; shifts = 5'd1;
        @(negedge clk);
        check("b2b_busy", 64'(busy), 64'(1));
        cnt = 1;
        while (cnt < 20 && !done) begin
            @(negedge clk);
            cnt++;
        end
        check("b2b_gap", 64'(cnt), 64'(6));
        @(posedge clk); #1;

        // Reset in the middle of RUN aborts the operation.
        issue(32'h0000_00AA, 5'd3, model(32'h0000_00AA, 5'd3));
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_done", 64'(done), 64'(0));
        check("abort_shifted", 64'(shifted), 64'(0));
        check("abort_c_out", 64'(c_out), 64'(0));
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) cnt++;
        end
        check("abort_no_done", 64'(cnt), 64'(0));
        @(posedge clk); #1;

        // Reset wins over start in the same cycle.
        rst = 1'b1; start = 1'b1; num = 32'h0000_0005; shifts = 5'd1;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        check("rst_prio_busy", 64'(busy), 64'(0));
        @(posedge clk); #1;

        // Random sweep against the reference model.
        for (int i = 0; i < 1000; i++) begin
            rn = $urandom;
            rs = 5'($urandom_range(0, 31));
            issue(rn, rs, model(rn, rs));
            wait_done(n);
            check("rand_latency", 64'(n), 64'(6));
        end

        repeat (3) @(negedge clk);
        check("sb_drained", 64'(sb.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
